m_wb_arbiter2: RTL and testbench
================================

Name: m_wb_arbiter2

Overview:
Two-master, one-slave Wishbone classic arbiter. It shares the single Wishbone slave bus in the ice40 simulation/hardware tops between the midgetv core (master 0) and a second master (master 1, e.g. a program loader or DMA engine).
- Grants whole bus cycles (CYC-framed) using round-robin or fixed priority.
- Forwards the granted master's signals to the slave side.
- A watchdog terminates cycles that are never acknowledged, so neither master can hang the bus.

Parameters:
- TMOBITS, 4: width of the watchdog counter. A stalled strobe is terminated after 2^TMOBITS-1 cycles without ACK_I.
- FIXEDPRIO, 0: 1 gives master 0 fixed priority on contention; 0 selects round-robin.

Ports:
CLK_I  in  1  system clock; all state on rising edge
RST_I  in  1  reset, synchronous, active-low (0 = reset)
m0_CYC_I  in  1  master 0 bus cycle request
m0_STB_I  in  1  master 0 strobe
m0_WE_I  in  1  master 0 write enable
m0_ADR_I  in  32  master 0 address
m0_DAT_I  in  32  master 0 write data
m0_SEL_I  in  4  master 0 byte selects
m0_ACK_O  out  1  acknowledge to master 0
m0_DAT_O  out  32  read data to master 0
m1_CYC_I, m1_STB_I, m1_WE_I, m1_ADR_I, m1_DAT_I, m1_SEL_I, m1_ACK_O, m1_DAT_O: same as the m0_ ports, for master 1
CYC_O  out  1  slave-side cycle
STB_O  out  1  slave-side strobe
WE_O  out  1  slave-side write enable
ADR_O  out  32  slave-side address
DAT_O  out  32  slave-side write data
SEL_O  out  4  slave-side byte selects
ACK_I  in  1  slave acknowledge
DAT_I  in  32  slave read data
gnt_o  out  2  one-hot current grant, {m1,m0}; 00 = idle
tmo_o  out  1  one-cycle pulse when the watchdog terminates a strobe

Behaviour:
- FSM states: IDLE, GNT0, GNT1. gnt_o is the registered state decode: IDLE=00, GNT0=01, GNT1=10.
- Reset (RST_I=0 at a clock edge):
  - state=IDLE, last_gnt=1 (so master 0 wins the first contention), watchdog=0.
  - All slave-side outputs 0, both ACK_O 0, tmo_o 0.
  - Reset mid-cycle drops the grant immediately on the next edge. No ACK is issued for the aborted strobe.
- IDLE:
  - Only m0_CYC_I=1: go to GNT0.
  - Only m1_CYC_I=1: go to GNT1.
  - Both=1 with FIXEDPRIO=1: go to GNT0.
  - Both=1 with FIXEDPRIO=0: grant the master that was not last_gnt.
  - last_gnt updates on entry to GNTx.
  - Arbitration latency: exactly one cycle from CYC assertion (in IDLE) to forwarding.
- GNTx:
  - CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O are combinational copies of master x's inputs.
  - The non-granted master sees ACK_O=0. Its strobe is never forwarded.
  - mx_ACK_O = ACK_I | wd_fire. mx_DAT_O = DAT_I, except 32'h0 on a wd_fire cycle.
  - Both masters' DAT_O carry DAT_I when not driven by the rules above, which simplifies muxing. ACK is the only qualifier.
- Leaving GNTx:
  - When mx_CYC_I=0 at an edge, go to IDLE. There is always one dead IDLE cycle between grants, so there is no back-to-back owner switch.
  - A master holding CYC across many strobes (pipelined bursts, read-modify-write) keeps the grant; the other master waits indefinitely.
- In IDLE all slave-side outputs are 0, including ADR_O, DAT_O and SEL_O.
- Watchdog (TMOBITS wide):
  - Clears when not in GNTx, when STB_O=0, or when ACK_I=1.
  - Otherwise increments.
  - wd_fire = (counter == all ones) & STB_O & ~ACK_I. It is combinational and forces a synthesized ACK to the granted master plus tmo_o=1 for that cycle.
  - The counter wraps to 0 on fire.
  - If ACK_I and the all-ones count coincide, it is a normal ACK: tmo_o=0.
- Simultaneous events:
  - A master dropping CYC while the other raises CYC: state goes to IDLE, then the waiting master is granted next cycle.
  - ACK_I while in IDLE is ignored.

Test Plan:
- Reset: hold RST_I=0 3 cycles with both CYC=1 -> gnt_o=00, CYC_O=0, ACKs=0. Release -> gnt_o=01 after 1 cycle.
- Single master 1 read: m1 CYC/STB, ADR=0x60000004. Slave ACKs 2 cycles later with DAT_I=0x12345678 -> m1_ACK_O=1 with m1_DAT_O=0x12345678; m0_ACK_O stays 0.
- Round-robin contention (FIXEDPRIO=0): both request continuously, each dropping CYC after 1 acked strobe -> grants alternate 01,00,10,00,01; FIXEDPRIO=1 -> always 01.
- Grant hold: m0 holds CYC across 4 strobes while m1 requests -> gnt_o stays 01 until m0_CYC_I=0, then 00, then 10.
- Watchdog: TMOBITS=4, slave never ACKs -> m0_ACK_O=1 with m0_DAT_O=0 and tmo_o=1 on the 16th cycle of STB_O; an ACK on the 15th cycle -> tmo_o=0.
- Reset mid-cycle: RST_I=0 during a GNT1 strobe -> gnt_o=00 and STB_O=0 after the edge, no ACK to m1.

Source files
------------

// File: rtl/m_wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with CYC-framed grants,
// round-robin or fixed priority, and an ACK watchdog on the granted strobe.
module m_wb_arbiter2 #(
    parameter int unsigned TMOBITS   = 4,
    parameter bit          FIXEDPRIO = 1'b0
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [31:0] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    input  logic [3:0]  m0_SEL_I,
    output logic        m0_ACK_O,
    output logic [31:0] m0_DAT_O,
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [31:0] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    input  logic [3:0]  m1_SEL_I,
    output logic        m1_ACK_O,
    output logic [31:0] m1_DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I,
    output logic [1:0]  gnt_o,
    output logic        tmo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 last_gnt;
    logic                 last_gnt_nxt;
    logic [TMOBITS-1:0]   wd_cnt;
    logic                 wd_fire;

    // State register; last_gnt=1 makes master 0 win the first contention.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Next-state: grants last a whole CYC frame, always via one IDLE cycle.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (m0_CYC_I && m1_CYC_I) begin
                    if (FIXEDPRIO || last_gnt) begin
                        state_nxt    = GNT0;
                        last_gnt_nxt = 1'b0;
                    end else begin
                        state_nxt    = GNT1;
                        last_gnt_nxt = 1'b1;
                    end
                end else if (m0_CYC_I) begin
                    state_nxt    = GNT0;
                    last_gnt_nxt = 1'b0;
                end else if (m1_CYC_I) begin
                    state_nxt    = GNT1;
                    last_gnt_nxt = 1'b1;
                end
            end
            GNT0:    if (!m0_CYC_I) state_nxt = IDLE;
            GNT1:    if (!m1_CYC_I) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side forwarding of the granted master; all zero when idle.
    always_comb begin
        CYC_O = 1'b0;
        STB_O = 1'b0;
        WE_O  = 1'b0;
        ADR_O = '0;
        DAT_O = '0;
        SEL_O = '0;
        case (state)
            GNT0: begin
                CYC_O = m0_CYC_I;
                STB_O = m0_STB_I;
                WE_O  = m0_WE_I;
                ADR_O = m0_ADR_I;
                DAT_O = m0_DAT_I;
                SEL_O = m0_SEL_I;
            end
            GNT1: begin
                CYC_O = m1_CYC_I;
                STB_O = m1_STB_I;
                WE_O  = m1_WE_I;
                ADR_O = m1_ADR_I;
                DAT_O = m1_DAT_I;
                SEL_O = m1_SEL_I;
            end
            default: ;
        endcase
    end

    // Watchdog counts consecutive unacknowledged strobe cycles; wraps on fire.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            wd_cnt <= '0;
        end else if (state == IDLE || !STB_O || ACK_I) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + TMOBITS'(1);
        end
    end

    assign wd_fire = (&wd_cnt) & STB_O & ~ACK_I;
    assign tmo_o   = wd_fire;
    assign gnt_o   = {state == GNT1, state == GNT0};

    assign m0_ACK_O = (state == GNT0) & (ACK_I | wd_fire);
    assign m1_ACK_O = (state == GNT1) & (ACK_I | wd_fire);
    assign m0_DAT_O = (state == GNT0 && wd_fire) ? 32'h0 : DAT_I;
    assign m1_DAT_O = (state == GNT1 && wd_fire) ? 32'h0 : DAT_I;

endmodule

// File: tb/tb_m_wb_arbiter2.sv
// Bench for m_wb_arbiter2: round-robin (u0) and fixed-priority (u1) copies
// share stimulus; a per-cycle ownership model plus directed literal checks.
module tb_m_wb_arbiter2;

    localparam int unsigned TMOBITS  = 4;
    localparam int          WD_LIMIT = 1 << TMOBITS;
    localparam logic [1:0]  EXP_SEQ [2][5] = '{'{2'b01, 2'b00, 2'b10, 2'b00, 2'b01},
                                              '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        ack_i;
    logic [31:0] dat_i;

    logic        s_cyc [2];
    logic        s_stb [2];
    logic        s_we  [2];
    logic [31:0] s_adr [2];
    logic [31:0] s_dat [2];
    logic [3:0]  s_sel [2];
    logic        ack0  [2];
    logic        ack1  [2];
    logic [31:0] dat0  [2];
    logic [31:0] dat1  [2];
    logic [1:0]  gnt   [2];
    logic        tmo   [2];

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    int owner [2] = '{-1, -1};
    int last  [2] = '{1, 1};
    int stall [2] = '{0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        m_wb_arbiter2 #(.TMOBITS(TMOBITS), .FIXEDPRIO(1'(g))) u_dut (
            .CLK_I(clk), .RST_I(rst_n),
            .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we),
            .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_SEL_I(m0_sel),
            .m0_ACK_O(ack0[g]), .m0_DAT_O(dat0[g]),
            .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we),
            .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_SEL_I(m1_sel),
            .m1_ACK_O(ack1[g]), .m1_DAT_O(dat1[g]),
            .CYC_O(s_cyc[g]), .STB_O(s_stb[g]), .WE_O(s_we[g]),
            .ADR_O(s_adr[g]), .DAT_O(s_dat[g]), .SEL_O(s_sel[g]),
            .ACK_I(ack_i), .DAT_I(dat_i),
            .gnt_o(gnt[g]), .tmo_o(tmo[g])
        );
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
        ack_i = 0; dat_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    // Model: who owns the bus and how long the current strobe has stalled.
    always @(negedge clk) begin : p_model
        logic [70:0] e_bus;
        logic [1:0]  e_gnt;
        logic        e_stb, fire, req0, req1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                if (owner[i] == 0)      e_bus = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel};
                else if (owner[i] == 1) e_bus = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_sel};
                else                    e_bus = '0;
                e_stb = e_bus[69];
                e_gnt = (owner[i] < 0) ? 2'b00 : ((owner[i] == 0) ? 2'b01 : 2'b10);
                fire  = (owner[i] >= 0) && e_stb && !ack_i && (stall[i] + 1 == WD_LIMIT);
                check($sformatf("u%0d gnt", i), 128'(gnt[i]), 128'(e_gnt));
                check($sformatf("u%0d slave_bus", i),
                      128'({s_cyc[i], s_stb[i], s_we[i], s_adr[i], s_dat[i], s_sel[i]}), 128'(e_bus));
                check($sformatf("u%0d acks", i), 128'({ack1[i], ack0[i]}),
                      128'({owner[i] == 1 && (ack_i || fire), owner[i] == 0 && (ack_i || fire)}));
                check($sformatf("u%0d m0_dat", i), 128'(dat0[i]),
                      128'((owner[i] == 0 && fire) ? 32'h0 : dat_i));
                check($sformatf("u%0d m1_dat", i), 128'(dat1[i]),
                      128'((owner[i] == 1 && fire) ? 32'h0 : dat_i));
                check($sformatf("u%0d tmo", i), 128'(tmo[i]), 128'(fire));
                if (!rst_n) begin
                    owner[i] = -1; last[i] = 1; stall[i] = 0;
                end else begin
                    stall[i] = ((owner[i] >= 0) && e_stb && !ack_i && !fire) ? stall[i] + 1 : 0;
                    req0 = m0_cyc;
                    req1 = m1_cyc;
                    if (owner[i] < 0) begin
                        if (req0 && req1) owner[i] = (i == 1 || last[i] == 1) ? 0 : 1;
                        else if (req0)    owner[i] = 0;
                        else if (req1)    owner[i] = 1;
                        if (owner[i] >= 0) last[i] = owner[i];
                    end else if (!((owner[i] == 0) ? req0 : req1)) begin
                        owner[i] = -1;
                    end
                end
            end
        end
    end

    initial begin : p_main
        logic [1:0] seqq [$];
        logic [1:0] prev, gv, got;
        int         c0, c1;
        idle_inputs();
        rst_n = 0;

        // Reset held with both masters requesting.
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1; ack_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_en = 1;
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rst u%0d gnt", i), 128'(gnt[i]), 128'(2'b00));
                check($sformatf("rst u%0d cyc_o", i), 128'(s_cyc[i]), 128'(1'b0));
                check($sformatf("rst u%0d acks", i), 128'({ack1[i], ack0[i]}), 128'(2'b00));
            end
        end
        rst_n = 1; ack_i = 0;
        tick();
        #1;
        check("rst_release u0 gnt", 128'(gnt[0]), 128'(2'b01));
        check("rst_release u1 gnt", 128'(gnt[1]), 128'(2'b01));
        idle_inputs();
        tick();
        tick();

        // Single master-1 read acknowledged two cycles after the grant.
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h6000_0004; m1_sel = 4'hF;
        tick();
        #1;
        check("m1rd gnt", 128'(gnt[0]), 128'(2'b10));
        check("m1rd adr_o", 128'(s_adr[0]), 128'(32'h6000_0004));
        tick();
        #1;
        check("m1rd early_ack", 128'(ack1[0]), 128'(1'b0));
        tick();
        ack_i = 1; dat_i = 32'h1234_5678;
        #1;
        check("m1rd ack", 128'(ack1[0]), 128'(1'b1));
        check("m1rd dat", 128'(dat1[0]), 128'(32'h1234_5678));
        check("m1rd m0_ack", 128'(ack0[0]), 128'(1'b0));
        tick();
        idle_inputs();
        tick();
        tick();

        // Continuous contention; each master drops CYC after one acked strobe.
        for (int ph = 0; ph < 2; ph++) begin
            apply_reset();
            ack_i = 1; dat_i = 32'hA5A5_0000;
            seqq.delete();
            prev = 2'b11; c0 = 0; c1 = 0;
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            for (int n = 0; n < 14; n++) begin
                tick();
                gv = gnt[ph];
                if (gv !== prev) begin
                    seqq.push_back(gv);
                    prev = gv;
                end
                c0 = (gv == 2'b01) ? c0 + 1 : 0;
                c1 = (gv == 2'b10) ? c1 + 1 : 0;
                m0_cyc = (c0 < 2); m0_stb = m0_cyc;
                m1_cyc = (c1 < 2); m1_stb = m1_cyc;
            end
            for (int k = 0; k < 5; k++) begin
                got = (k < seqq.size()) ? seqq[k] : 2'b11;
                check($sformatf("contend u%0d seq[%0d]", ph, k), 128'(got), 128'(EXP_SEQ[ph][k]));
            end
            idle_inputs();
            tick();
        end

        // Master 0 keeps the grant across four strobes while master 1 waits.
        apply_reset();
        m0_cyc = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0100; m0_sel = 4'h3;
        tick();
        #1;
        check("hold first gnt", 128'(gnt[0]), 128'(2'b01));
        for (int k = 0; k < 4; k++) begin
            m0_stb = 1; ack_i = 1; m0_adr = 32'(k * 4); dat_i = 32'(k + 7);
            #1;
            check($sformatf("hold s%0d gnt", k), 128'(gnt[0]), 128'(2'b01));
            check($sformatf("hold s%0d acks", k), 128'({ack1[0], ack0[0]}), 128'(2'b01));
            tick();
            m0_stb = 0; ack_i = 0;
            #1;
            check($sformatf("hold gap%0d gnt", k), 128'(gnt[0]), 128'(2'b01));
            tick();
        end
        m0_cyc = 0;
        tick();
        #1;
        check("hold release idle", 128'(gnt[0]), 128'(2'b00));
        tick();
        #1;
        check("hold handover", 128'(gnt[0]), 128'(2'b10));
        idle_inputs();
        tick();
        tick();

        // Watchdog: stalled strobe fires on its 16th cycle; ACK at 15 or 16 wins.
        apply_reset();
        dat_i = 32'hDEAD_BEEF;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0040;
        tick();
        for (int n = 1; n <= WD_LIMIT; n++) begin
            #1;
            check($sformatf("wd c%0d tmo", n), 128'(tmo[0]), 128'(n == WD_LIMIT));
            if (n == WD_LIMIT) begin
                check("wd fire ack", 128'(ack0[0]), 128'(1'b1));
                check("wd fire dat", 128'(dat0[0]), 128'(32'h0));
            end
            tick();
        end
        for (int r = 0; r < 2; r++) begin
            for (int n = 1; n <= WD_LIMIT - 1 + r; n++) begin
                ack_i = (n == WD_LIMIT - 1 + r);
                #1;
                check($sformatf("wd r%0d c%0d tmo", r, n), 128'(tmo[0]), 128'(1'b0));
                if (ack_i) begin
                    check($sformatf("wd r%0d ack", r), 128'(ack0[0]), 128'(1'b1));
                    check($sformatf("wd r%0d dat", r), 128'(dat0[0]), 128'(32'hDEAD_BEEF));
                end
                tick();
                ack_i = 0;
            end
        end
        idle_inputs();
        tick();
        tick();

        // Reset in the middle of a master-1 strobe.
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h6000_0008;
        tick();
        #1;
        check("midrst pre stb", 128'(s_stb[0]), 128'(1'b1));
        rst_n = 0;
        tick();
        #1;
        check("midrst gnt", 128'(gnt[0]), 128'(2'b00));
        check("midrst stb_o", 128'(s_stb[0]), 128'(1'b0));
        check("midrst m1_ack", 128'(ack1[0]), 128'(1'b0));
        rst_n = 1; m1_cyc = 0; m1_stb = 0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
